// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-read sequencer: state encoding,
// transfer-direction encoding and the default thermal-sensor address.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_ADDR  = 4'd1,
    ST_WR_HI    = 4'd2,
    ST_WR_LO    = 4'd3,
    ST_WR_STOP  = 4'd4,
    ST_RD_ADDR  = 4'd5,
    ST_RD_HI    = 4'd6,
    ST_RD_LO    = 4'd7,
    ST_RD_STOP  = 4'd8,
    ST_ERR_STOP = 4'd9
  } state_e;

  localparam logic       I2C_READ            = 1'b1;
  localparam logic       I2C_WRITE           = 1'b0;
  localparam logic [6:0] SENSOR_ADDR_DEFAULT = 7'h33;

endpackage

// File: rtl/i2c_register_reader.sv
// Drives i2c_controller to write a 16-bit register pointer, then read back
// N big-endian 16-bit words, strobing each assembled word downstream.
module i2c_register_reader
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEVICE_ADDRESS = SENSOR_ADDR_DEFAULT,
  parameter int         COUNT_WIDTH    = 10,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [15:0]            register_address,
  input  logic [COUNT_WIDTH-1:0] word_count,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [15:0]            word_data,
  output logic                   word_valid,
  input  logic                   i2c_idle,
  input  logic                   i2c_ack,
  input  logic                   i2c_nack,
  input  logic [7:0]             i2c_received_data,
  output logic [6:0]             i2c_address,
  output logic                   i2c_read_write,
  output logic [7:0]             i2c_transmit_data,
  output logic                   i2c_enable_transfer
);

  localparam int             TW           = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TIMER_RELOAD = TW'(TIMEOUT_CYCLES);

  state_e                 state_q, state_d;
  logic [15:0]            reg_addr_q, reg_addr_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [7:0]             high_q, high_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic [15:0]            word_data_q, word_data_d;
  logic                   word_valid_q, word_valid_d;
  logic                   rw_q, rw_d;
  logic [7:0]             tx_q, tx_d;
  logic                   en_q, en_d;
  logic [6:0]             dev_addr_q;

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d      = state_q;
    reg_addr_d   = reg_addr_q;
    remaining_d  = remaining_q;
    high_d       = high_q;
    timer_d      = timer_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = 1'b0;
    word_data_d  = word_data_q;
    word_valid_d = 1'b0;
    rw_d         = rw_q;
    tx_d         = tx_q;
    en_d         = en_q;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          busy_d      = 1'b1;
          reg_addr_d  = register_address;
          remaining_d = word_count;
          if (word_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_WR_ADDR;
            en_d    = 1'b1;
            rw_d    = I2C_WRITE;
            tx_d    = register_address[15:8];
            timer_d = TIMER_RELOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      // Byte in flight: nack beats ack, and silence counts down to a timeout.
      ST_WR_ADDR, ST_WR_HI, ST_WR_LO, ST_RD_ADDR, ST_RD_HI, ST_RD_LO: begin
        if (i2c_nack) begin
          state_d = ST_ERR_STOP;
          en_d    = 1'b0;
        end else if (i2c_ack) begin
          timer_d = TIMER_RELOAD;
          case (state_q)
            ST_WR_ADDR: state_d = ST_WR_HI;
            ST_WR_HI: begin
              tx_d    = reg_addr_q[7:0];
              state_d = ST_WR_LO;
            end
            ST_WR_LO: begin
              en_d    = 1'b0;
              state_d = ST_WR_STOP;
            end
            ST_RD_ADDR: state_d = ST_RD_HI;
            ST_RD_HI: begin
              high_d  = i2c_received_data;
              state_d = ST_RD_LO;
            end
            ST_RD_LO: begin
              word_data_d  = {high_q, i2c_received_data};
              word_valid_d = 1'b1;
              remaining_d  = remaining_q - COUNT_WIDTH'(1);
              if (remaining_q == COUNT_WIDTH'(1)) begin
                en_d    = 1'b0;
                state_d = ST_RD_STOP;
              end else begin
                state_d = ST_RD_HI;
              end
            end
            default: state_d = ST_ERR_STOP;
          endcase
        end else if (timer_q <= TW'(1)) begin
          timer_d = '0;
          state_d = ST_ERR_STOP;
          en_d    = 1'b0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      ST_WR_STOP: begin
        if (i2c_idle) begin
          state_d = ST_RD_ADDR;
          rw_d    = I2C_READ;
          en_d    = 1'b1;
          timer_d = TIMER_RELOAD;
        end else begin
          state_d = ST_WR_STOP;
        end
      end

      ST_RD_STOP: begin
        if (i2c_idle) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_RD_STOP;
        end
      end

      ST_ERR_STOP: begin
        en_d = 1'b0;
        if (i2c_idle) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else begin
          state_d = ST_ERR_STOP;
        end
      end

      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops the bus enable immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      reg_addr_q   <= 16'h0000;
      remaining_q  <= '0;
      high_q       <= 8'h00;
      timer_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      word_data_q  <= 16'h0000;
      word_valid_q <= 1'b0;
      rw_q         <= 1'b0;
      tx_q         <= 8'h00;
      en_q         <= 1'b0;
      dev_addr_q   <= DEVICE_ADDRESS;
    end else begin
      state_q      <= state_d;
      reg_addr_q   <= reg_addr_d;
      remaining_q  <= remaining_d;
      high_q       <= high_d;
      timer_q      <= timer_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      word_data_q  <= word_data_d;
      word_valid_q <= word_valid_d;
      rw_q         <= rw_d;
      tx_q         <= tx_d;
      en_q         <= en_d;
      dev_addr_q   <= DEVICE_ADDRESS;
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign error               = error_q;
  assign word_data           = word_data_q;
  assign word_valid          = word_valid_q;
  assign i2c_address         = dev_addr_q;
  assign i2c_read_write      = rw_q;
  assign i2c_transmit_data   = tx_q;
  assign i2c_enable_transfer = en_q;

endmodule

// File: tb/tb_i2c_register_reader.sv
// Bench for i2c_register_reader: a cycle-level controller/sensor stand-in plus
// a request-level scoreboard of expected bus bytes, words, done and error.
module tb_i2c_register_reader;

  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   register_address = 16'h0000;
  logic [CW-1:0] word_count = '0;
  logic          busy, done, error, word_valid;
  logic [15:0]   word_data;
  logic          i2c_idle = 1'b1;
  logic          i2c_ack = 1'b0;
  logic          i2c_nack = 1'b0;
  logic [7:0]    i2c_received_data = 8'h00;
  logic [6:0]    i2c_address;
  logic          i2c_read_write;
  logic [7:0]    i2c_transmit_data;
  logic          i2c_enable_transfer;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  i2c_register_reader #(
    .DEVICE_ADDRESS (7'h33),
    .COUNT_WIDTH    (CW),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .register_address    (register_address),
    .word_count          (word_count),
    .busy                (busy),
    .done                (done),
    .error               (error),
    .word_data           (word_data),
    .word_valid          (word_valid),
    .i2c_idle            (i2c_idle),
    .i2c_ack             (i2c_ack),
    .i2c_nack            (i2c_nack),
    .i2c_received_data   (i2c_received_data),
    .i2c_address         (i2c_address),
    .i2c_read_write      (i2c_read_write),
    .i2c_transmit_data   (i2c_transmit_data),
    .i2c_enable_transfer (i2c_enable_transfer)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Controller/sensor stand-in: bytes returned by the sensor come from rd_q,
  // bytes the controller would shift out are logged in wr_q.
  logic [7:0] rd_q[$];
  logic [7:0] wr_q[$];
  int   f_nack_rw = -1, f_nack_idx = -1, f_stall_rw = -1, f_stall_idx = -1;
  bit   m_active = 1'b0, m_rw = 1'b0, m_sample = 1'b0;
  int   m_idx = 0, m_cnt = 0, m_stop = 0;
  logic [7:0] m_tx = 8'h00;
  logic [6:0] m_addr = 7'h00;

  initial forever begin
    @(negedge clk);
    i2c_ack  = 1'b0;
    i2c_nack = 1'b0;
    if (m_stop > 0) begin
      m_stop--;
      if (m_stop == 0) i2c_idle = 1'b1;
    end else if (!m_active) begin
      if (i2c_enable_transfer && i2c_idle) begin
        m_active = 1'b1;
        i2c_idle = 1'b0;
        m_rw     = i2c_read_write;
        m_addr   = i2c_address;
        m_idx    = 0;
        m_sample = 1'b0;
        m_cnt    = $urandom_range(3, 6);
      end
    end else if (!i2c_enable_transfer) begin
      m_active = 1'b0;
      m_stop   = $urandom_range(2, 5);
    end else begin
      if (m_sample) begin
        m_tx     = i2c_transmit_data;
        m_sample = 1'b0;
      end
      if (!(int'(m_rw) == f_stall_rw && m_idx == f_stall_idx)) begin
        if (m_cnt > 1) begin
          m_cnt--;
        end else begin
          if (int'(m_rw) == f_nack_rw && m_idx == f_nack_idx) begin
            i2c_nack = 1'b1;
          end else begin
            i2c_ack = 1'b1;
            if (m_rw && m_idx > 0) begin
              if (rd_q.size() > 0) i2c_received_data = rd_q.pop_front();
              else i2c_received_data = 8'($urandom);
            end
            if (!m_rw && m_idx > 0) wr_q.push_back(m_tx);
            m_sample = !m_rw;
          end
          m_idx++;
          m_cnt = $urandom_range(3, 6);
        end
      end
    end
  end

  logic [15:0] got_w[$];
  int done_cnt = 0, err_cnt = 0, en_cycles = 0, bad = 0;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      if (word_valid) got_w.push_back(word_data);
      if (done) done_cnt++;
      if (done && error) err_cnt++;
      if (error && !done) bad++;
      if (done && !busy) bad++;
      if (i2c_enable_transfer) en_cycles++;
    end
  end

  task automatic run_req(input logic [15:0] ra, input logic [CW-1:0] n, input int exp_words,
                         input bit exp_err, input bit exp_wr, input bit restart);
    logic [7:0] eb[$];
    int t;
    eb = rd_q;
    got_w.delete();
    wr_q.delete();
    done_cnt = 0; err_cnt = 0; en_cycles = 0; bad = 0;
    @(negedge clk);
    register_address = ra;
    word_count = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    if (n == '0) begin
      check("zero_done_next_cycle", done, 1);
      check("zero_error_low", error, 0);
    end
    if (restart) begin
      repeat (4) @(negedge clk);
      register_address = ~ra;
      word_count = '0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    t = 0;
    while (done_cnt == 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("done_within_budget", (t < 5000), 1);
    repeat (6) @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("error_pulses", err_cnt, exp_err);
    check("protocol_bad", bad, 0);
    check("busy_low_after", busy, 0);
    check("enable_low_after", i2c_enable_transfer, 0);
    check("word_total", got_w.size(), exp_words);
    for (int i = 0; i < exp_words && i < got_w.size(); i++)
      check($sformatf("word%0d", i), got_w[i], {eb[2*i], eb[2*i+1]});
    if (exp_wr) begin
      check("wr_bytes", wr_q.size(), 2);
      if (wr_q.size() == 2) begin
        check("wr_hi", wr_q[0], ra[15:8]);
        check("wr_lo", wr_q[1], ra[7:0]);
      end
      check("bus_addr", m_addr, 7'h33);
      check("last_xfer_read", m_rw, 1);
    end else begin
      check("wr_bytes_none", wr_q.size(), 0);
    end
    if (n == '0) check("zero_no_enable", en_cycles, 0);
    rd_q.delete();
    f_nack_rw = -1; f_nack_idx = -1; f_stall_rw = -1; f_stall_idx = -1;
  endtask

  initial begin
    int t;
    int n;
    int k;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_en", i2c_enable_transfer, 0);
    check("rst_addr", i2c_address, 7'h33);
    check("rst_word", word_data, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    rd_q = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    run_req(16'h2400, 10'd2, 2, 1'b0, 1'b1, 1'b1);

    f_nack_rw = 0; f_nack_idx = 0;
    run_req(16'h1111, 10'd3, 0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) rd_q.push_back(8'($urandom));
    f_stall_rw = 1; f_stall_idx = 3;
    run_req(16'h5A3C, 10'd3, 1, 1'b1, 1'b1, 1'b0);

    run_req(16'h0800, 10'd0, 0, 1'b0, 1'b0, 1'b0);

    // Reset while the sequencer waits on the first read byte.
    for (int i = 0; i < 6; i++) rd_q.push_back(8'($urandom));
    @(negedge clk);
    register_address = 16'h0102;
    word_count = 10'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!(m_active && m_rw && m_idx == 1) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("reach_rd_hi", (t < 2000), 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_error", error, 0);
    check("mid_rst_valid", word_valid, 0);
    check("mid_rst_en", i2c_enable_transfer, 0);
    check("mid_rst_rw", i2c_read_write, 0);
    check("mid_rst_tx", i2c_transmit_data, 0);
    check("mid_rst_word", word_data, 0);
    check("mid_rst_addr", i2c_address, 7'h33);
    @(negedge clk);
    reset = 1'b1;
    t = 0;
    while (!(i2c_idle && !m_active && m_stop == 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("bus_recovered", (t < 100), 1);
    rd_q.delete();

    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < 2 * n; i++) rd_q.push_back(8'($urandom));
      if (r % 2 == 1) begin
        k = $urandom_range(1, 2 * n);
        f_nack_rw = 1; f_nack_idx = k;
        run_req(16'($urandom), CW'(n), (k - 1) / 2, 1'b1, 1'b1, 1'b0);
      end else begin
        run_req(16'($urandom), CW'(n), n, 1'b0, 1'b1, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
